// File: rtl/pwm_sat_modulator_pkg.sv
// Shared control definitions: gate FSM encoding, clamp and saturating-subtract helpers.
// The arithmetic helpers are reused by the PI loop and other control blocks.
package pwm_sat_modulator_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    DT_H = 3'd1,
    HIGH = 3'd2,
    DT_L = 3'd3,
    LOW  = 3'd4
  } gate_state_t;

  localparam logic signed [31:0] S32_MAX = 32'sh7FFF_FFFF;
  localparam logic signed [31:0] S32_MIN = 32'sh8000_0000;

  function automatic logic signed [31:0] clamp_s32(
    input logic signed [31:0] value,
    input logic signed [31:0] lo,
    input logic signed [31:0] hi
  );
    if (value < lo)      return lo;
    else if (value > hi) return hi;
    else                 return value;
  endfunction

  // Difference is formed at 33 bits so an overflow is visible as a sign disagreement.
  function automatic logic signed [31:0] sat_sub_s32(
    input logic signed [31:0] a,
    input logic signed [31:0] b
  );
    logic [32:0] diff;
    diff = {a[31], a} - {b[31], b};
    if (diff[32] != diff[31]) return diff[32] ? S32_MIN : S32_MAX;
    else                      return diff[31:0];
  endfunction

endpackage

// File: rtl/pwm_sat_modulator_deadtime_gen.sv
// Complementary gate FSM with dead-time insertion for one converter leg.
// Gates are registered from the next state, so they lag the demand by one cycle.
module pwm_sat_modulator_deadtime_gen
  import pwm_sat_modulator_pkg::*;
#(
  parameter int DEADTIME = 10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic dem,
  output logic q_h,
  output logic q_l
);

  localparam int DT_W = $clog2(DEADTIME + 1);
  localparam logic [DT_W-1:0] DT_LOAD = DT_W'(DEADTIME);
  localparam logic [DT_W-1:0] DT_LAST = DT_W'(1);

  gate_state_t     state;
  logic [DT_W-1:0] dt_cnt;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      dt_cnt <= '0;
      q_h    <= 1'b0;
      q_l    <= 1'b0;
    end else if (!en) begin
      state  <= IDLE;
      dt_cnt <= '0;
      q_h    <= 1'b0;
      q_l    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          state  <= dem ? DT_H : DT_L;
          dt_cnt <= DT_LOAD;
          q_h    <= 1'b0;
          q_l    <= 1'b0;
        end
        DT_H: begin
          // Abandoning toward LOW is safe: the high side never turned on.
          if (!dem) begin
            state  <= LOW;
            dt_cnt <= '0;
            q_h    <= 1'b0;
            q_l    <= 1'b1;
          end else if (dt_cnt <= DT_LAST) begin
            state  <= HIGH;
            dt_cnt <= '0;
            q_h    <= 1'b1;
            q_l    <= 1'b0;
          end else begin
            dt_cnt <= dt_cnt - 1'b1;
          end
        end
        HIGH: begin
          if (!dem) begin
            state  <= DT_L;
            dt_cnt <= DT_LOAD;
            q_h    <= 1'b0;
            q_l    <= 1'b0;
          end
        end
        DT_L: begin
          if (dem) begin
            state  <= HIGH;
            dt_cnt <= '0;
            q_h    <= 1'b1;
            q_l    <= 1'b0;
          end else if (dt_cnt <= DT_LAST) begin
            state  <= LOW;
            dt_cnt <= '0;
            q_h    <= 1'b0;
            q_l    <= 1'b1;
          end else begin
            dt_cnt <= dt_cnt - 1'b1;
          end
        end
        LOW: begin
          if (dem) begin
            state  <= DT_H;
            dt_cnt <= DT_LOAD;
            q_h    <= 1'b0;
            q_l    <= 1'b0;
          end
        end
        default: begin
          state  <= IDLE;
          dt_cnt <= '0;
          q_h    <= 1'b0;
          q_l    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/pwm_sat_modulator.sv
// Saturating PWM modulator: carrier counter, period-boundary duty sampler with
// anti-windup excess, and a dead-time protected complementary gate pair.
module pwm_sat_modulator
  import pwm_sat_modulator_pkg::*;
#(
  parameter int CNT_W    = 16,
  parameter int PERIOD   = 1000,
  parameter int DUTY_MIN = 50,
  parameter int DUTY_MAX = 950,
  parameter int DEADTIME = 10
) (
  input  logic                    i_CLK,
  input  logic                    i_RST,
  input  logic                    i_EN,
  input  logic signed [31:0]      i_U,
  output logic                    o_Q_H,
  output logic                    o_Q_L,
  output logic signed [31:0]      o_AW,
  output logic                    o_SAT,
  output logic                    o_SYNC,
  output logic [CNT_W-1:0]        o_DUTY
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PERIOD - 1);

  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   cnt_next;
  logic               running;
  logic               start;
  logic               wrap;
  logic               sample;
  logic               dem;
  logic signed [31:0] duty_sat;
  logic signed [31:0] aw_next;

  // NOTE: every signal driven here gets a value on every path, so no latch is inferred.
  always_comb begin
    start    = i_EN && !running;
    wrap     = (cnt == CNT_LAST);
    sample   = i_EN && (start || wrap);
    cnt_next = (!i_EN || start || wrap) ? '0 : cnt + 1'b1;
    duty_sat = clamp_s32(i_U, 32'(DUTY_MIN), 32'(DUTY_MAX));
    aw_next  = sat_sub_s32(i_U, duty_sat);
    dem      = (cnt < o_DUTY);
  end

  // Duty only loads when the counter is about to return to 0, so a period
  // always runs with one duty value.
  always_ff @(posedge i_CLK or negedge i_RST) begin
    if (!i_RST) begin
      running <= 1'b0;
      cnt     <= '0;
      o_SYNC  <= 1'b0;
      o_DUTY  <= CNT_W'(DUTY_MIN);
      o_AW    <= '0;
      o_SAT   <= 1'b0;
    end else begin
      running <= i_EN;
      cnt     <= cnt_next;
      o_SYNC  <= i_EN && (cnt_next == '0);
      if (!i_EN) begin
        o_AW  <= '0;
        o_SAT <= 1'b0;
      end else if (sample) begin
        o_DUTY <= duty_sat[CNT_W-1:0];
        o_AW   <= aw_next;
        o_SAT  <= (i_U != duty_sat);
      end
    end
  end

  pwm_sat_modulator_deadtime_gen #(
    .DEADTIME (DEADTIME)
  ) u_deadtime_gen (
    .clk   (i_CLK),
    .rst_n (i_RST),
    .en    (i_EN),
    .dem   (dem),
    .q_h   (o_Q_H),
    .q_l   (o_Q_L)
  );

endmodule

// File: tb/tb_pwm_sat_modulator.sv
// Directed bench for pwm_sat_modulator: duty/anti-windup scoreboard checked at
// each carrier sync, plus gate timing, enable, reset and overflow checks.
module tb_pwm_sat_modulator;

  localparam int CNT_W  = 16;
  localparam int PERIOD = 100;
  localparam int DMIN   = 10;
  localparam int DMAX   = 90;
  localparam int DT     = 3;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               en;
  logic signed [31:0] u;
  logic               q_h;
  logic               q_l;
  logic signed [31:0] aw;
  logic               sat;
  logic               sync;
  logic [CNT_W-1:0]   duty;

  int total = 0;
  int bad   = 0;

  typedef struct {
    longint duty;
    longint aw;
    longint sat;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  pwm_sat_modulator #(
    .CNT_W    (CNT_W),
    .PERIOD   (PERIOD),
    .DUTY_MIN (DMIN),
    .DUTY_MAX (DMAX),
    .DEADTIME (DT)
  ) dut (
    .i_CLK  (clk),
    .i_RST  (rst_n),
    .i_EN   (en),
    .i_U    (u),
    .o_Q_H  (q_h),
    .o_Q_L  (q_l),
    .o_AW   (aw),
    .o_SAT  (sat),
    .o_SYNC (sync),
    .o_DUTY (duty)
  );

  task automatic check(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] expv);
    total++;
    assert (obs === expv)
    else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // Reference saturation in 64-bit arithmetic, independent of the RTL helpers.
  function automatic exp_t model(input longint v);
    exp_t   e;
    longint d;
    longint a;
    d = (v < DMIN) ? longint'(DMIN) : (v > DMAX) ? longint'(DMAX) : v;
    a = v - d;
    if (a > 64'sh7FFF_FFFF)  a = 64'sh7FFF_FFFF;
    if (a < -64'sh8000_0000) a = -64'sh8000_0000;
    e.duty = d;
    e.aw   = a;
    e.sat  = (v != d) ? 1 : 0;
    return e;
  endfunction

  task automatic drive_u(input logic signed [31:0] v);
    u = v;
    sb.push_back(model(longint'(v)));
  endtask

  task automatic pop_check(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      total++;
      bad++;
      $error("FAIL %s_sb: observed=empty expected=pending entry", tag);
    end else begin
      e = sb.pop_front();
      check({tag, "_duty"}, duty, e.duty);
      check({tag, "_aw"},   aw,   e.aw);
      check({tag, "_sat"},  sat,  e.sat);
    end
  endtask

  task automatic wait_sync(input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 2 * PERIOD && !seen; i++) begin
      @(negedge clk);
      seen = sync;
    end
    check({tag, "_sync"}, seen, 1);
  endtask

  task automatic wait_qh(input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 2 * PERIOD && !seen; i++) begin
      @(negedge clk);
      seen = q_h;
    end
    check({tag, "_qh"}, seen, 1);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_qh"},   q_h,  0);
    check({tag, "_ql"},   q_l,  0);
    check({tag, "_aw"},   aw,   0);
    check({tag, "_sat"},  sat,  0);
    check({tag, "_sync"}, sync, 0);
    check({tag, "_duty"}, duty, DMIN);
  endtask

  // Shoot-through guard, sampled every cycle of the run.
  always @(negedge clk) begin
    total++;
    assert (!(q_h && q_l))
    else begin
      bad++;
      $error("FAIL overlap: observed q_h=%b q_l=%b expected not both 1", q_h, q_l);
    end
  end

  initial begin
    int nh;
    int nl;
    int no;

    rst_n = 1'b0;
    en    = 1'b0;
    u     = '0;
    repeat (3) @(negedge clk);
    check_reset_vals("reset");

    rst_n = 1'b1;
    @(negedge clk);
    drive_u(40);
    en = 1'b1;
    wait_sync("first");
    pop_check("first");

    // Steady-state period with duty 40.
    wait_sync("steady");
    nh = 0; nl = 0; no = 0;
    for (int i = 0; i < PERIOD; i++) begin
      if (i > 0) @(negedge clk);
      nh += int'(q_h);
      nl += int'(q_l);
      no += int'(!q_h && !q_l);
    end
    check("on_h40", nh, 37);
    check("on_l40", nl, 57);
    check("gap40",  no, 6);

    // Command changes mid-period; current period must keep duty 40.
    wait_sync("mid");
    nh = 0;
    for (int i = 0; i < PERIOD; i++) begin
      if (i > 0) @(negedge clk);
      if (i == 20) drive_u(60);
      nh += int'(q_h);
    end
    check("keep40", nh, 37);
    wait_sync("d60");
    pop_check("d60");
    nh = 0;
    for (int i = 0; i < PERIOD; i++) begin
      if (i > 0) @(negedge clk);
      nh += int'(q_h);
    end
    check("apply60", nh, 57);

    // Saturation on both sides.
    drive_u(150);
    wait_sync("hi");
    pop_check("hi");
    drive_u(-20);
    wait_sync("lo");
    pop_check("lo");

    // Disable while high side is on.
    wait_qh("dis");
    en = 1'b0;
    @(negedge clk);
    check("dis_qh",   q_h,  0);
    check("dis_ql",   q_l,  0);
    check("dis_aw",   aw,   0);
    check("dis_sat",  sat,  0);
    check("dis_duty", duty, DMIN);

    // Re-enable: sampled immediately, then a full dead-time before any gate.
    drive_u(40);
    en = 1'b1;
    @(negedge clk);
    check("reen_sync", sync, 1);
    pop_check("reen");
    no = 0;
    for (int i = 0; i < 20 && !q_h && !q_l; i++) begin
      no++;
      @(negedge clk);
    end
    check("reen_gap", no, DT);
    check("reen_h",   q_h, 1);

    // Asynchronous reset while high side is on.
    wait_qh("rst");
    #2;
    rst_n = 1'b0;
    en    = 1'b0;
    #1;
    check("async_qh", q_h, 0);
    check_reset_vals("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Extreme commands must clamp and saturate without wrapping.
    drive_u(32'sh7FFF_FFFF);
    en = 1'b1;
    wait_sync("max");
    pop_check("max");
    drive_u(32'sh8000_0000);
    wait_sync("min");
    pop_check("min");
    repeat (PERIOD) @(negedge clk);
    en = 1'b0;
    repeat (3) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pwm_sat_modulator.md
Name: pwm_sat_modulator

Overview:
- Actuator-side companion to the PI controller.
- Converts the signed 32-bit PI command into a fixed-frequency, complementary, dead-time-protected gate pair for one converter leg.
- Saturates the command to a legal duty window and returns the saturation excess as the signed anti-windup signal that feeds the PI `aw` input.
- Sits between the PI output and the gate-driver pins.

Parameters:
- CNT_W, 16, width of the carrier counter and duty registers.
- PERIOD, 1000, carrier period in i_CLK cycles (2..2^CNT_W-1).
- DUTY_MIN, 50, lower duty clamp in counts (>= DEADTIME).
- DUTY_MAX, 950, upper duty clamp in counts (<= PERIOD-DEADTIME, > DUTY_MIN).
- DEADTIME, 10, dead-time in i_CLK cycles (>= 1).

Ports:
- i_CLK, input, 1, system clock.
- i_RST, input, 1, reset; asynchronous, active-low.
- i_EN, input, 1, modulator enable; low forces both gates off.
- i_U, input, 32 signed, duty command in counts (PI o_PI).
- o_Q_H, output, 1, high-side gate.
- o_Q_L, output, 1, low-side gate.
- o_AW, output, 32 signed, anti-windup excess: i_U minus saturated duty.
- o_SAT, output, 1, high while the latched duty is clamped.
- o_SYNC, output, 1, one-cycle pulse at carrier count 0.
- o_DUTY, output, CNT_W, duty currently applied (unsigned counts).

Behaviour:
- Reset (i_RST=0, asynchronous) values:
  - o_Q_H=0, o_Q_L=0, o_AW=0, o_SAT=0, o_SYNC=0, o_DUTY=DUTY_MIN.
  - Counter=0, FSM=IDLE, dead-time counter=0.
- Carrier:
  - Counter runs 0..PERIOD-1 while enabled, then wraps to 0.
  - Counter is held at 0 while i_EN=0.
  - o_SYNC is registered: it is 1 in the cycle in which the counter equals 0 and i_EN=1.
- Sampling:
  - i_U is sampled only on the cycle the counter equals PERIOD-1, and on the first i_EN=1 cycle after IDLE.
  - Saturation, computed as full 32-bit signed: duty_sat = DUTY_MIN if i_U < DUTY_MIN; DUTY_MAX if i_U > DUTY_MAX; otherwise i_U[CNT_W-1:0].
  - o_DUTY <= duty_sat, o_AW <= i_U - duty_sat, o_SAT <= (i_U != duty_sat). All three update together.
  - Duty is shadow-latched, so a new value takes effect from the next counter 0. There are no mid-period duty changes.
- Demand: dem = (counter < o_DUTY). dem is evaluated every cycle.
- FSM states: IDLE, DT_H (both off, heading high), HIGH, DT_L (both off, heading low), LOW.
  - IDLE: both gates off. When i_EN=1, go to DT_H if dem else DT_L, and load the dead-time counter with DEADTIME.
  - DT_H: both gates off. Decrement the dead-time counter. At 0, go to HIGH. If dem drops before expiry, go to LOW directly; this is safe because the high side never turned on.
  - HIGH: o_Q_H=1. When !dem, go to DT_L and reload the dead-time counter.
  - DT_L: mirror of DT_H. At expiry go to LOW; if dem rises before expiry, go to HIGH directly.
  - LOW: o_Q_L=1. When dem, go to DT_H and reload the dead-time counter.
- Gate outputs are registered from the next state, with 1 cycle of latency from the dem change.
- o_Q_H and o_Q_L are never both 1 in any cycle, including across reset and enable edges.
- Each gate's on-pulse is reduced by DEADTIME relative to the ideal PWM edge.
- i_EN falling edge, in any state:
  - Next cycle: both gates 0, FSM=IDLE, counter=0.
  - o_AW=0, o_SAT=0; o_DUTY is held.
- Reset mid-operation: gates drop asynchronously, and all state returns to reset values.
- Overflow: i_U near ±2^31 must not wrap into the duty window. The comparisons are signed 32-bit, and o_AW is computed as 33-bit then saturated to 32-bit signed.

Decomposition:
- Shared control package holds:
  - the FSM state encoding constants (IDLE/DT_H/HIGH/DT_L/LOW);
  - a clamp function (signed value, min, max → clamped value);
  - the 32-bit signed saturating-subtract function, which the PI and other loops reuse.
- One natural sub-module: deadtime_gen (dem, enable → Q_H/Q_L FSM with counter), reusable for the second leg.
- The counter and sampler stay in the top module.

Test Plan (PERIOD=100, DUTY_MIN=10, DUTY_MAX=90, DEADTIME=3):
- Reset then i_EN=1, i_U=40:
  - first sync at count 0, o_DUTY=40, o_AW=0, o_SAT=0;
  - o_Q_H high 37 cycles per period, o_Q_L high 57 cycles, two 3-cycle both-off gaps.
- i_U=150 held:
  - after the next PERIOD-1 sample, o_DUTY=90, o_AW=60, o_SAT=1;
  - i_U=-20 then gives o_DUTY=10, o_AW=-30.
- i_U changes 40→60 at count 20: the current period keeps duty 40, and duty 60 applies from the next count 0.
- i_EN deasserted while o_Q_H=1: both gates 0 next cycle, o_AW=0. Re-enable: both off for 3 cycles before the first gate asserts.
- i_RST pulsed low mid-HIGH: o_Q_H falls without waiting for a clock edge, and all outputs take reset values.
- i_U=0x7FFFFFFF and i_U=0x80000000: o_DUTY clamps to 90 and 10 respectively, o_AW saturates without wrap, and the overlap assertion holds for every cycle of the run.
